// File: rtl/bsg_lfsr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bsg_lfsr_pkg : shared widths and defaults for the LFSR consumers     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package bsg_lfsr_pkg;
  localparam int LFSR_WIDTH_DEFAULT  = 16;
  localparam int OUT_WIDTH_DEFAULT   = 8;
  localparam int MAX_REJECTS_DEFAULT = 4;
endpackage
`default_nettype wire

// File: rtl/bsg_lfsr_bound_mask.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bsg_lfsr_bound_mask : bound -> smeared (bound-1) mask, zero flag     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module bsg_lfsr_bound_mask #(
  parameter int OUT_WIDTH = 8
) (
  input  logic [OUT_WIDTH-1:0] i_bound,
  output logic [OUT_WIDTH-1:0] o_mask,
  output logic                 o_bound_zero
);
  logic [OUT_WIDTH-1:0] w_m;

  assign w_m          = i_bound - OUT_WIDTH'(1);
  assign o_bound_zero = (i_bound == '0);

  // Bound of zero wraps w_m to all ones, which is exactly the mask wanted.
  always_comb begin
    o_mask = '0;
    o_mask[OUT_WIDTH-1] = w_m[OUT_WIDTH-1];
    for (int i = OUT_WIDTH - 2; i >= 0; i--) begin
      o_mask[i] = o_mask[i+1] | w_m[i];
    end
  end
endmodule
`default_nettype wire

// File: rtl/bsg_lfsr_bounded_rng.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bsg_lfsr_bounded_rng : LFSR words -> uniform samples in [0, bound)   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module bsg_lfsr_bounded_rng
  import bsg_lfsr_pkg::*;
#(
  parameter int lfsr_width_p  = LFSR_WIDTH_DEFAULT,
  parameter int out_width_p   = OUT_WIDTH_DEFAULT,
  parameter int max_rejects_p = MAX_REJECTS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic [lfsr_width_p-1:0] lfsr_i,
  output logic                    yumi_o,
  input  logic [out_width_p-1:0]  bound_i,
  output logic                    v_o,
  output logic [out_width_p-1:0]  data_o,
  input  logic                    yumi_i
);
  localparam int CNT_W = $clog2(max_rejects_p + 1);

  logic [out_width_p-1:0] w_mask;
  logic                   w_bound_zero;
  logic [out_width_p-1:0] w_cand;
  logic                   w_eval;
  logic                   w_accept;
  logic                   w_last;

  logic                   r_v;
  logic [out_width_p-1:0] r_data;
  logic [CNT_W-1:0]       r_cnt;

  bsg_lfsr_bound_mask #(
    .OUT_WIDTH (out_width_p)
  ) u_mask (
    .i_bound      (bound_i),
    .o_mask       (w_mask),
    .o_bound_zero (w_bound_zero)
  );

  generate
    if (lfsr_width_p > out_width_p) begin : g_hi_bits
      logic w_unused_lfsr_hi;
      assign w_unused_lfsr_hi = ^lfsr_i[lfsr_width_p-1:out_width_p];
    end
  endgenerate

  assign w_cand   = lfsr_i[out_width_p-1:0] & w_mask;
  assign w_eval   = (~r_v | yumi_i) & ~reset_i;
  assign w_accept = w_bound_zero | (w_cand < bound_i);
  assign w_last   = (r_cnt == CNT_W'(max_rejects_p - 1));
  assign yumi_o   = w_eval;
  assign v_o      = r_v;
  assign data_o   = r_data;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_v    <= 1'b0;
      r_data <= '0;
      r_cnt  <= '0;
    end else if (w_eval) begin
      if (w_accept) begin
        r_v    <= 1'b1;
        r_data <= w_cand;
        r_cnt  <= '0;
      end else if (w_last) begin
        // cand < 2*bound here, so one subtraction lands inside the range
        r_v    <= 1'b1;
        r_data <= w_cand - bound_i;
        r_cnt  <= '0;
      end else begin
        r_v    <= 1'b0;
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  a_yumi_needs_valid : assert property (@(posedge clk) disable iff (reset_i) (yumi_i |-> r_v));
endmodule
`default_nettype wire

// File: tb/tb_bsg_lfsr_bounded_rng.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bsg_lfsr_bounded_rng : directed table-driven bench                |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_bsg_lfsr_bounded_rng;
  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [15:0] lfsr_i = '0;
  logic        yumi_o;
  logic [7:0]  bound_i = '0;
  logic        v_o;
  logic [7:0]  data_o;
  logic        yumi_i = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bsg_lfsr_bounded_rng #(
    .lfsr_width_p  (16),
    .out_width_p   (8),
    .max_rejects_p (4)
  ) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .lfsr_i  (lfsr_i),
    .yumi_o  (yumi_o),
    .bound_i (bound_i),
    .v_o     (v_o),
    .data_o  (data_o),
    .yumi_i  (yumi_i)
  );

  typedef struct {
    logic        rst;
    logic [7:0]  bound;
    logic [15:0] lfsr;
    logic        yi;
    logic        exp_yo;
    logic        exp_v;
    logic        chk_d;
    logic [7:0]  exp_d;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [7:0] bound,
                              input logic [15:0] lfsr, input logic yi,
                              input logic exp_yo, input logic exp_v,
                              input logic chk_d, input logic [7:0] exp_d,
                              input string name);
    vec_t v;
    v.rst = rst; v.bound = bound; v.lfsr = lfsr; v.yi = yi;
    v.exp_yo = exp_yo; v.exp_v = exp_v; v.chk_d = chk_d; v.exp_d = exp_d;
    v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Drive on the falling edge, check yumi_o combinationally, check registers after the rising edge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    reset_i = v.rst;
    bound_i = v.bound;
    lfsr_i  = v.lfsr;
    yumi_i  = v.yi;
    #1;
    check({v.name, ".yumi_o"}, 16'(yumi_o), 16'(v.exp_yo));
    @(posedge clk);
    #1;
    check({v.name, ".v_o"}, 16'(v_o), 16'(v.exp_v));
    if (v.chk_d) check({v.name, ".data_o"}, 16'(data_o), 16'(v.exp_d));
  endtask

  initial begin
    // reset held three cycles
    for (int i = 0; i < 3; i++) add(1, 8'd10, 16'h0000, 0, 0, 0, 1, 8'h00, "reset");
    // bound 0: no masking, no rejection, back-to-back
    add(0, 8'd0,  16'h1234, 0, 1, 1, 1, 8'h34, "b0_first");
    add(0, 8'd0,  16'hABCD, 1, 1, 1, 1, 8'hCD, "b0_second");
    add(0, 8'd0,  16'h5A77, 1, 1, 1, 1, 8'h77, "b0_third");
    // bound 10: reject 12, then accept 3
    add(0, 8'd10, 16'h00FC, 1, 1, 0, 0, 8'h00, "b10_rej");
    add(0, 8'd10, 16'h0013, 0, 1, 1, 1, 8'h03, "b10_acc");
    // three rejects then fallback 12-10=2
    add(0, 8'd10, 16'h00FC, 1, 1, 0, 0, 8'h00, "fb_rej1");
    add(0, 8'd10, 16'h12FC, 0, 1, 0, 0, 8'h00, "fb_rej2");
    add(0, 8'd10, 16'h34FC, 0, 1, 0, 0, 8'h00, "fb_rej3");
    add(0, 8'd10, 16'h56FC, 0, 1, 1, 1, 8'h02, "fb_accept");
    // counter cleared: another full run of three rejects needed
    add(0, 8'd10, 16'h00FC, 1, 1, 0, 0, 8'h00, "fb2_rej1");
    add(0, 8'd10, 16'h00FC, 0, 1, 0, 0, 8'h00, "fb2_rej2");
    add(0, 8'd10, 16'h00FC, 0, 1, 0, 0, 8'h00, "fb2_rej3");
    add(0, 8'd10, 16'h00FC, 0, 1, 1, 1, 8'h02, "fb2_accept");
    // backpressure: words and bound change, held sample must not
    for (int i = 0; i < 5; i++)
      add(0, (i % 2 == 0) ? 8'd3 : 8'd10, 16'(16'h0101 * (i + 1)), 0, 0, 1, 1, 8'h02, "hold");
    add(0, 8'd10, 16'h0005, 1, 1, 1, 1, 8'h05, "hold_release");
    // bound 1 -> always 0; bound 16 -> mask 0xF, never rejects
    add(0, 8'd1,  16'hFFFF, 1, 1, 1, 1, 8'h00, "b1_a");
    add(0, 8'd1,  16'h1234, 1, 1, 1, 1, 8'h00, "b1_b");
    add(0, 8'd16, 16'h00FF, 1, 1, 1, 1, 8'h0F, "b16_a");
    add(0, 8'd16, 16'h00F0, 1, 1, 1, 1, 8'h00, "b16_b");
    add(0, 8'd16, 16'hEE0A, 1, 1, 1, 1, 8'h0A, "b16_c");
    // reset with two rejects pending
    add(0, 8'd10, 16'h00FC, 1, 1, 0, 0, 8'h00, "mid_rej1");
    add(0, 8'd10, 16'h00FC, 0, 1, 0, 0, 8'h00, "mid_rej2");
    add(1, 8'd10, 16'h00FC, 0, 0, 0, 1, 8'h00, "mid_reset");
    add(0, 8'd10, 16'h00FC, 0, 1, 0, 0, 8'h00, "post_rej1");
    add(0, 8'd10, 16'h00FC, 0, 1, 0, 0, 8'h00, "post_rej2");
    add(0, 8'd10, 16'h00FC, 0, 1, 0, 0, 8'h00, "post_rej3");
    add(0, 8'd10, 16'h00FC, 0, 1, 1, 1, 8'h02, "post_fallback");
    // reset while a sample is held
    add(1, 8'd0,  16'h0099, 0, 0, 0, 1, 8'h00, "v_reset");
    add(0, 8'd0,  16'h0099, 0, 1, 1, 1, 8'h99, "v_release");
    add(0, 8'd0,  16'h0042, 1, 1, 1, 1, 8'h42, "v_next");

    foreach (vecs[i]) apply(vecs[i]);

    // odd-width bound sweep: every accepted sample below its bound
    for (int b = 2; b < 40; b += 7) begin
      @(negedge clk);
      bound_i = 8'(b);
      lfsr_i  = 16'($urandom);
      yumi_i  = v_o;
      @(posedge clk);
      #1;
      total++;
      if (v_o && data_o >= 8'(b)) begin
        bad++;
        $display("FAIL sweep_b%0d: got 0x%0h expected below 0x%0h", b, data_o, b);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
